// File: rtl/pc_sequencer_pkg.sv
// Shared processor package for the fetch sequencer: FSM encoding and the
// fixed instruction word / PC step sizes.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } seq_state_e;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_STEP     = 4;

endpackage

// File: rtl/pc_sequencer_program_counter.sv
// Program counter register: loads the next PC chosen by the sequencer every cycle.
module pc_sequencer_program_counter #(
   parameter int                N_BITS   = 32,
   parameter logic [N_BITS-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_BITS-1:0] pc_d,
   output logic [N_BITS-1:0] pc_q
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: issues fetches, delivers words to decode, and
// applies jump/branch redirects and halt.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int                N_BITS   = 32,
   parameter logic [N_BITS-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req_o,
   output logic [N_BITS-1:0]      imem_addr_o,
   input  logic                   imem_ack_i,
   input  logic [INSTR_WIDTH-1:0] imem_data_i,
   output logic                   instr_valid_o,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [N_BITS-1:0]      instr_pc_o,
   input  logic                   stall_i,
   input  logic                   jump_i,
   input  logic [N_BITS-1:0]      jump_target_i,
   input  logic                   branch_i,
   input  logic [N_BITS-1:0]      branch_target_i,
   input  logic                   halt_i
);

   seq_state_e             state_q, state_d;
   logic [N_BITS-1:0]      pc_q, pc_d;
   logic                   pend_valid_q, pend_valid_d;
   logic [N_BITS-1:0]      pend_target_q, pend_target_d;
   logic                   halt_q, halt_d;
   logic                   valid_q, valid_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [N_BITS-1:0]      instr_pc_q, instr_pc_d;

   logic                   redirect;
   logic [N_BITS-1:0]      redirect_target;
   logic [N_BITS-1:0]      pc_seq;

   assign redirect        = jump_i | branch_i;
   assign redirect_target = (jump_i ? jump_target_i : branch_target_i) & ~N_BITS'(3);
   assign pc_seq          = pc_q + N_BITS'(PC_STEP);

   pc_sequencer_program_counter #(
      .N_BITS   (N_BITS),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk   (clk),
      .reset (reset),
      .pc_d  (pc_d),
      .pc_q  (pc_q)
   );

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      halt_d        = halt_q;
      valid_d       = valid_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      imem_req_o    = 1'b0;

      unique case (state_q)
         IDLE: begin
            state_d = halt_i ? HALTED : FETCH;
            if (redirect) pc_d = redirect_target;
         end

         FETCH: begin
            imem_req_o = 1'b1;
            if (!imem_ack_i) begin
               // Request in flight: the address must not move, so redirects and halt wait.
               valid_d = valid_q & stall_i;
               if (redirect) begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = redirect_target;
               end
               if (halt_i) halt_d = 1'b1;
            end else if (redirect || pend_valid_q) begin
               pc_d         = redirect ? redirect_target : pend_target_q;
               pend_valid_d = 1'b0;
               valid_d      = 1'b0;
               if (halt_i || halt_q) begin
                  state_d = HALTED;
                  halt_d  = 1'b0;
               end
            end else begin
               pc_d       = pc_seq;
               valid_d    = 1'b1;
               instr_d    = imem_data_i;
               instr_pc_d = pc_q;
               if (stall_i || halt_i || halt_q) begin
                  state_d = HOLD;
                  halt_d  = halt_i | halt_q;
               end
            end
         end

         HOLD: begin
            if (redirect || !stall_i) begin
               if (redirect) pc_d = redirect_target;
               valid_d = 1'b0;
               state_d = (halt_i || halt_q) ? HALTED : FETCH;
               halt_d  = 1'b0;
            end else if (halt_i) begin
               halt_d = 1'b1;
            end
         end

         HALTED: begin
            valid_d = 1'b0;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         halt_q        <= 1'b0;
         valid_q       <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         halt_q        <= halt_d;
         valid_q       <= valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

   assign imem_addr_o   = pc_q;
   assign instr_valid_o = valid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected deliveries are queued when the ack
// is driven and compared when decode consumes them.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        stall_i;
   logic        jump_i;
   logic [31:0] jump_target_i;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic        halt_i;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   pc_sequencer #(.N_BITS(32), .RESET_PC(32'h0)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ack_i      (imem_ack_i),
      .imem_data_i     (imem_data_i),
      .instr_valid_o   (instr_valid_o),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .stall_i         (stall_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .halt_i          (halt_i)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Consumption point: a shown instruction is taken when decode is not stalling.
   always @(negedge clk) begin
      if (reset === 1'b1 && instr_valid_o === 1'b1 && stall_i === 1'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_delivery_pc", {32'h0, instr_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            check("delivery_instr", {32'h0, instr_o}, {32'h0, e[63:32]});
            check("delivery_pc", {32'h0, instr_pc_o}, {32'h0, e[31:0]});
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_step(input string tag, input logic [31:0] addr, input logic ack,
                             input logic exp_valid, input logic deliver);
      imem_ack_i  = ack;
      imem_data_i = mem_word(addr);
      @(negedge clk);
      check({tag, "_req"}, {63'h0, imem_req_o}, 64'h1);
      check({tag, "_addr"}, {32'h0, imem_addr_o}, {32'h0, addr});
      check({tag, "_valid"}, {63'h0, instr_valid_o}, {63'h0, exp_valid});
      if (deliver) sb.push_back({mem_word(addr), addr});
      next_cycle();
      imem_ack_i = 1'b0;
      jump_i     = 1'b0;
      branch_i   = 1'b0;
      halt_i     = 1'b0;
   endtask

   task automatic check_quiet(input string tag, input logic exp_valid, input logic [31:0] exp_addr);
      @(negedge clk);
      check({tag, "_req"}, {63'h0, imem_req_o}, 64'h0);
      check({tag, "_valid"}, {63'h0, instr_valid_o}, {63'h0, exp_valid});
      check({tag, "_addr"}, {32'h0, imem_addr_o}, {32'h0, exp_addr});
   endtask

   task automatic restart();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      check_quiet("idle", 1'b0, 32'h0);
      next_cycle();
      imem_ack_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      imem_ack_i = 1'b0; imem_data_i = '0; stall_i = 1'b0;
      jump_i = 1'b0; jump_target_i = '0; branch_i = 1'b0; branch_target_i = '0; halt_i = 1'b0;

      @(negedge clk);
      check("rst_req", {63'h0, imem_req_o}, 64'h0);
      check("rst_valid", {63'h0, instr_valid_o}, 64'h0);
      check("rst_instr", {32'h0, instr_o}, 64'h0);
      check("rst_instr_pc", {32'h0, instr_pc_o}, 64'h0);
      check("rst_addr", {32'h0, imem_addr_o}, 64'h0);
      next_cycle();
      restart();

      // Back-to-back acks: zero-bubble delivery.
      fetch_step("a0", 32'h0, 1'b1, 1'b0, 1'b1);
      fetch_step("a4", 32'h4, 1'b1, 1'b1, 1'b1);
      fetch_step("a8", 32'h8, 1'b1, 1'b1, 1'b1);
      fetch_step("aC", 32'hC, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      check("a10_valid", {63'h0, instr_valid_o}, 64'h1);
      next_cycle();
      restart();

      // Delayed ack at 0x8, then stall at delivery of 0xC.
      fetch_step("b0", 32'h0, 1'b1, 1'b0, 1'b1);
      fetch_step("b4", 32'h4, 1'b1, 1'b1, 1'b1);
      fetch_step("b8_w0", 32'h8, 1'b0, 1'b1, 1'b0);
      fetch_step("b8_w1", 32'h8, 1'b0, 1'b0, 1'b0);
      fetch_step("b8_w2", 32'h8, 1'b0, 1'b0, 1'b0);
      fetch_step("b8_ack", 32'h8, 1'b1, 1'b0, 1'b1);
      fetch_step("bC_w0", 32'hC, 1'b0, 1'b1, 1'b0);
      stall_i = 1'b1;
      fetch_step("bC_ack", 32'hC, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         check_quiet("hold", 1'b1, 32'h10);
         check("hold_instr", {32'h0, instr_o}, {32'h0, mem_word(32'hC)});
         check("hold_instr_pc", {32'h0, instr_pc_o}, 64'hC);
         next_cycle();
      end
      stall_i = 1'b0;
      check_quiet("hold_release", 1'b1, 32'h10);
      next_cycle();

      // Redirect priority and target alignment.
      branch_i = 1'b1; branch_target_i = 32'h40;
      jump_i   = 1'b1; jump_target_i   = 32'h80;
      fetch_step("b10_both", 32'h10, 1'b1, 1'b0, 1'b0);
      branch_i = 1'b1; branch_target_i = 32'h43;
      fetch_step("b80_br43", 32'h80, 1'b1, 1'b0, 1'b0);
      jump_i = 1'b1; jump_target_i = 32'h20;
      fetch_step("b40_j20", 32'h40, 1'b1, 1'b0, 1'b0);

      // Branch while 0x20 is outstanding: word discarded, pending target used.
      branch_i = 1'b1; branch_target_i = 32'h100;
      fetch_step("b20_w0", 32'h20, 1'b0, 1'b0, 1'b0);
      fetch_step("b20_w1", 32'h20, 1'b0, 1'b0, 1'b0);
      fetch_step("b20_ack", 32'h20, 1'b1, 1'b0, 1'b0);
      fetch_step("b100", 32'h100, 1'b1, 1'b0, 1'b1);
      jump_i = 1'b1; jump_target_i = 32'h24;
      fetch_step("b104_j24", 32'h104, 1'b1, 1'b1, 1'b0);

      // Reset mid-request at 0x24, with a late ack straddling reset.
      @(negedge clk);
      check("b24_req", {63'h0, imem_req_o}, 64'h1);
      check("b24_addr", {32'h0, imem_addr_o}, 64'h24);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_req", {63'h0, imem_req_o}, 64'h0);
      check("mid_rst_addr", {32'h0, imem_addr_o}, 64'h0);
      check("mid_rst_valid", {63'h0, instr_valid_o}, 64'h0);
      check("mid_rst_instr", {32'h0, instr_o}, 64'h0);
      check("mid_rst_instr_pc", {32'h0, instr_pc_o}, 64'h0);
      imem_ack_i = 1'b1;
      imem_data_i = 32'hDEAD_BEEF;
      next_cycle();
      reset = 1'b1;
      check_quiet("late_ack_idle", 1'b0, 32'h0);
      next_cycle();
      imem_ack_i = 1'b0;

      // Halt requested while 0x4 is outstanding: deliver it, then stop.
      fetch_step("c0", 32'h0, 1'b1, 1'b0, 1'b1);
      halt_i = 1'b1;
      fetch_step("c4_w0", 32'h4, 1'b0, 1'b1, 1'b0);
      fetch_step("c4_ack", 32'h4, 1'b1, 1'b0, 1'b1);
      check_quiet("halt_drain", 1'b1, 32'h8);
      next_cycle();
      imem_ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_quiet("halted", 1'b0, 32'h8);
         next_cycle();
      end
      imem_ack_i = 1'b0;

      check("scoreboard_empty", 64'(sb.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter N_BITS, default 32, PC and address width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_o  output  1  fetch request to instruction memory.
REQ-006 imem_addr_o  output  N_BITS  fetch address, equals current PC register.
REQ-007 imem_ack_i  input  1  memory returns imem_data_i this cycle.
REQ-008 imem_data_i  input  32  fetched instruction word.
REQ-009 instr_valid_o  output  1  instr_o/instr_pc_o valid toward decode.
REQ-010 instr_o  output  32  delivered instruction.
REQ-011 instr_pc_o  output  N_BITS  address of delivered instruction.
REQ-012 stall_i  input  1  decode cannot accept; hold delivered instruction.
REQ-013 jump_i  input  1  jump redirect request, target on jump_target_i.
REQ-014 jump_target_i  input  N_BITS  jump target address.
REQ-015 branch_i  input  1  taken-branch redirect request, target on branch_target_i.
REQ-016 branch_target_i  input  N_BITS  branch target address.
REQ-017 halt_i  input  1  stop fetching after current delivery.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, HOLD, HALTED.
REQ-019 IDLE: one cycle after reset release, imem_req_o=0, next state FETCH.
REQ-020 FETCH: imem_req_o=1; imem_addr_o SHALL stay stable until imem_ack_i=1.
REQ-021 FETCH with ack, no redirect, stall_i=0: instr_valid_o=1 next cycle with instr_o=imem_data_i, instr_pc_o=PC; PC<=PC+4; stay FETCH (one instruction per ack, zero bubble).
REQ-022 FETCH with ack and stall_i=1: capture instruction, PC<=PC+4, go HOLD.
REQ-023 HOLD: imem_req_o=0; instr_valid_o, instr_o, instr_pc_o held unchanged; on stall_i=0 go FETCH.
REQ-024 instr_valid_o SHALL drop to 0 the cycle after a delivery consumed with stall_i=0 and no new ack.
REQ-025 Redirect priority: jump_i over branch_i when both high; redirect over sequential PC+4.
REQ-026 Redirect in a cycle with no outstanding request or coincident with ack: PC<=target, the acked word discarded (no instr_valid_o), stay/go FETCH.
REQ-027 Redirect while request outstanding without ack: target latched in pending register; current request held until ack; acked word discarded; PC<=pending target; pending cleared.
REQ-028 Second redirect while pending SHALL overwrite pending target (latest wins).
REQ-029 Redirect in HOLD: held instruction dropped (instr_valid_o=0 next cycle), PC<=target, go FETCH.
REQ-030 Targets SHALL have bits [1:0] forced to 0; PC+4 SHALL wrap modulo 2^N_BITS.
REQ-031 halt_i: finish any outstanding request (deliver or discard per above), then HALTED; HALTED has imem_req_o=0, instr_valid_o=0, PC frozen; only reset exits.
REQ-032 halt_i and redirect same cycle: redirect applied to PC, then halt.

Reset
REQ-033 reset=0 SHALL immediately force: state IDLE, PC=RESET_PC, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, pending cleared.
REQ-034 Reset mid-request SHALL abandon the request; a late imem_ack_i after reset SHALL be ignored until FETCH is re-entered.

Structure
REQ-035 State encoding, INSTR_WIDTH=32 and PC_STEP=4 SHALL live in the shared processor package.
REQ-036 PC register SHALL be the existing Program_Counter sub-module, instantiated once, fed by sequencer next-PC mux.

Verification
REQ-037 Reset release, ack every cycle -> imem_addr_o 0,4,8,C; instr_pc_o same sequence one cycle later, no bubbles.
REQ-038 Ack delayed 3 cycles at addr 0x8 -> imem_addr_o held 0x8 all 3 cycles, single delivery.
REQ-039 stall_i=1 two cycles at delivery of 0xC -> instr_o/instr_pc_o=0xC held, imem_req_o=0, resume fetch 0x10.
REQ-040 branch_i target 0x40 and jump_i target 0x80 same cycle -> next fetch 0x80; branch target 0x43 alone -> fetch 0x40.
REQ-041 branch to 0x100 while fetch 0x20 outstanding, ack 2 cycles later -> 0x20 word not delivered, next fetch 0x100.
REQ-042 Reset asserted mid-FETCH at 0x24 -> outputs cleared same cycle, restart at RESET_PC; halt_i -> HALTED, imem_req_o stays 0.
